// File: rtl/debug_frame_tx.sv
// debug_frame_tx: serialises a snapshot of the pipeline debug bus to the UART
// as HEADER, LEN, payload bytes (ascending index), CSUM = XOR(LEN, payload).
// Full-bus and windowed dumps. Handshake: strobe wr_uart when tx_busy=0, then
// wait for tx_busy=1 before preparing the next byte.
module debug_frame_tx #(
  parameter int unsigned BUS_BYTES = 217,
  parameter int unsigned IDX_W     = 8,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   send_start,
  input  logic                   mode,
  input  logic [IDX_W-1:0]       win_start,
  input  logic [IDX_W-1:0]       win_len,
  input  logic [8*BUS_BYTES-1:0] send_data,
  input  logic                   tx_busy,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   data_sent,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned DATA_W = 8 * BUS_BYTES;
  localparam int unsigned SUM_W  = IDX_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] PH_HDR  = 2'd0;
  localparam logic [1:0] PH_LEN  = 2'd1;
  localparam logic [1:0] PH_DATA = 2'd2;
  localparam logic [1:0] PH_CSUM = 2'd3;

  logic [1:0]        state_q, state_n;
  logic [1:0]        phase_q, phase_n;
  logic [DATA_W-1:0] snap_q, snap_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [IDX_W-1:0]  cnt_q, cnt_n;
  logic [7:0]        csum_q, csum_n;
  logic [7:0]        len_q, len_n;
  logic              wr_uart_n;
  logic [7:0]        w_data_n;
  logic              data_sent_n;
  logic              busy_n;
  logic              err_n;

  logic [SUM_W-1:0]  win_sum;
  logic              win_ok;
  logic [7:0]        cur_byte;
  logic [7:0]        phase_byte;

  // Window check at IDX_W+1 bits so start+len can never wrap.
  always_comb begin
    win_sum = SUM_W'(win_start) + SUM_W'(win_len);
    win_ok  = (win_len != '0) && (win_sum <= SUM_W'(BUS_BYTES));
  end

  // Select snapshot byte at idx_q; byte 0 sits at the MSB end of the bus.
  always_comb begin
    cur_byte = 8'h00;
    for (int unsigned i = 0; i < BUS_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_byte = snap_q[8*(BUS_BYTES-1-i) +: 8];
      end
    end
  end

  // Byte to transmit for the current frame phase.
  always_comb begin
    case (phase_q)
      PH_HDR:  phase_byte = HEADER;
      PH_LEN:  phase_byte = len_q;
      PH_DATA: phase_byte = cur_byte;
      default: phase_byte = csum_q;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    phase_n     = phase_q;
    snap_n      = snap_q;
    idx_n       = idx_q;
    cnt_n       = cnt_q;
    csum_n      = csum_q;
    len_n       = len_q;
    wr_uart_n   = 1'b0;
    w_data_n    = w_data;
    data_sent_n = 1'b0;
    err_n       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (send_start) begin
          if (mode && !win_ok) begin
            err_n = 1'b1;
          end else begin
            snap_n  = send_data;
            idx_n   = mode ? win_start : '0;
            cnt_n   = mode ? win_len : IDX_W'(BUS_BYTES);
            len_n   = mode ? 8'(win_len) : 8'(BUS_BYTES);
            csum_n  = 8'h00;
            phase_n = PH_HDR;
            state_n = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        if (!tx_busy) begin
          wr_uart_n = 1'b1;
          w_data_n  = phase_byte;
          state_n   = S_ACK;
          if (phase_q == PH_LEN) begin
            csum_n = csum_q ^ len_q;
          end
          if (phase_q == PH_DATA) begin
            csum_n = csum_q ^ cur_byte;
            idx_n  = idx_q + IDX_W'(1);
            cnt_n  = cnt_q - IDX_W'(1);
          end
        end
      end

      S_ACK: begin
        if (tx_busy) begin
          state_n = S_EMIT;
          case (phase_q)
            PH_HDR:  phase_n = PH_LEN;
            PH_LEN:  phase_n = (cnt_q == '0) ? PH_CSUM : PH_DATA;
            PH_DATA: phase_n = (cnt_q == '0) ? PH_CSUM : PH_DATA;
            default: state_n = S_DONE;
          endcase
        end
      end

      default: begin
        if (!tx_busy) begin
          data_sent_n = 1'b1;
          state_n     = S_IDLE;
        end
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_HDR;
      snap_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      csum_q    <= 8'h00;
      len_q     <= 8'h00;
      wr_uart   <= 1'b0;
      w_data    <= 8'h00;
      data_sent <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_n;
      phase_q   <= phase_n;
      snap_q    <= snap_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      csum_q    <= csum_n;
      len_q     <= len_n;
      wr_uart   <= wr_uart_n;
      w_data    <= w_data_n;
      data_sent <= data_sent_n;
      busy      <= busy_n;
      err       <= err_n;
    end
  end

endmodule

// File: doc/debug_frame_tx.md
# debug_frame_tx

Parametrised successor to the debugger transmit unit. Serialises a snapshot of the pipeline debug bus over the UART transmitter as a framed packet: header, length, payload, checksum. Supports full-bus dumps and windowed dumps of any byte range. Sits between the debugger receive FSM, which issues `send_start`, and the UART `tx_busy`/`wr_uart`/`w_data` handshake.

## Interface
- `BUS_BYTES`, default 217: debug bus width in bytes; legal range 1..255.
- `IDX_W`, default 8: width of the window index and length fields; must satisfy 2^IDX_W > BUS_BYTES.
- `HEADER`, default 8'hA5: first byte of every frame.
- `clock` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `send_start` in 1: request a frame; sampled only in IDLE.
- `mode` in 1: 0 = full dump, 1 = window; sampled with `send_start`.
- `win_start` in IDX_W: first payload byte index in window mode.
- `win_len` in IDX_W: payload byte count in window mode.
- `send_data` in 8*BUS_BYTES: debug bus; byte index 0 = bits [8*BUS_BYTES-1 -: 8] (MSB first).
- `tx_busy` in 1: UART transmitter busy.
- `wr_uart` out 1: one-cycle write strobe to the UART.
- `w_data` out 8: byte to transmit; valid while `wr_uart`=1.
- `data_sent` out 1: one-cycle pulse when a frame completes.
- `busy` out 1: high whenever state is not IDLE.
- `err` out 1: one-cycle pulse when a request is rejected.

## Operation
- Frame: HEADER, LEN, payload bytes in ascending index, CSUM.
  - LEN = BUS_BYTES (full) or `win_len` (window), 8 bits.
  - CSUM = XOR of LEN and all payload bytes; HEADER is excluded.
- Accepting a request (IDLE and `send_start`=1):
  - Window-mode validity: `win_len`≠0 and `win_start`+`win_len` ≤ BUS_BYTES. The sum is computed at IDX_W+1 bits, so it cannot wrap.
  - Invalid: pulse `err` next cycle, stay IDLE, no `wr_uart`.
  - Valid: capture `send_data` into the snapshot register; load the byte index (0 or `win_start`) and remaining count; clear the checksum; go to EMIT with phase HDR.
- Changes to `send_data` after capture do not affect the frame in flight.
- States:
  - IDLE: wait for a request.
  - EMIT: when `tx_busy`=0, drive `w_data` with the current phase byte, pulse `wr_uart`, go to ACK. Otherwise hold.
  - ACK: hold until `tx_busy`=1, then advance phase: HDR→LEN→DATA→CSUM. DATA repeats until the remaining count reaches 0. After CSUM go to DONE; otherwise go to EMIT.
  - DONE: wait for `tx_busy`=0, pulse `data_sent`, go to IDLE.
- Checksum accumulator XORs in LEN and each DATA byte when its strobe is issued.
- `send_start` outside IDLE is ignored: no queueing, no `err`.

## Timing
- Reset values: state IDLE; `wr_uart`, `data_sent`, `err`, `busy` = 0; `w_data` = 8'h00; snapshot, index, count and checksum cleared.
- Reset asserted mid-frame: next edge returns to IDLE. No further strobe, no `data_sent`. A partial frame on the line is abandoned.
- Request accept → first `wr_uart`: 1 cycle if `tx_busy`=0.
- At most one `wr_uart` per observed `tx_busy` rising edge. Never two strobes without an intervening `tx_busy`=1 cycle.
- A frame emits exactly LEN+3 strobes.
- `data_sent` fires ≥1 cycle after the CSUM byte is accepted, on the first cycle `tx_busy`=0 in DONE. It is never concurrent with `wr_uart`.
- `busy` rises the cycle after accept and falls in the same cycle as the `data_sent` pulse.
- `tx_busy` stuck high: the block holds in EMIT or DONE indefinitely; no timeout.

## Test plan
- Full dump: BUS_BYTES=4, `send_data`=32'h11223344, UART model busy 10 cycles per byte → bytes A5 04 11 22 33 44 40; one `data_sent` pulse.
- Window: same data, `mode`=1, `win_start`=1, `win_len`=2 → A5 02 22 33 13.
- Invalid window: `win_start`=3, `win_len`=2, then `win_len`=0 → one `err` pulse each; zero `wr_uart`; `busy` stays 0.
- Snapshot hold: change `send_data` to 32'hFFFFFFFF one cycle after accept → frame still A5 04 11 22 33 44 40. `send_start` pulsed mid-frame → ignored.
- Back-pressure: hold `tx_busy`=1 for 50 cycles at request → no strobe until release, then normal frame. Check no double strobe when `tx_busy` rises 3 cycles late.
- Reset mid-frame: assert `reset` after the third strobe → all outputs 0 next cycle; a new request afterwards yields a complete, correct frame.
